// File: rtl/register_scoreboard_pkg.sv
// Shared constants and index helpers for the register scoreboard.
package register_scoreboard_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int NUM_WB_PORTS = 4;
    localparam int SB_IDX_W     = REG_ADDR_W + 1;
    localparam int SB_ENTRIES   = 2 * NUM_REGS;

    // Counter index: float-file registers occupy the upper half.
    function automatic logic [SB_IDX_W-1:0] sb_index(input logic is_float,
                                                     input logic [REG_ADDR_W-1:0] addr);
        return {is_float, addr};
    endfunction

    // Integer r0 is hardwired and never tracked.
    function automatic logic is_int_zero(input logic is_float,
                                         input logic [REG_ADDR_W-1:0] addr);
        return (!is_float) && (addr == '0);
    endfunction

endpackage

// File: rtl/register_scoreboard_if.sv
// Decode/issue/writeback bundle seen by the register scoreboard.
interface register_scoreboard_if #(
    parameter int TOTAL_W = 8
);
    import register_scoreboard_pkg::*;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_addr;
    logic                  issue_float;
    logic                  issue_ready;

    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic                  rs_float;
    logic                  rt_float;
    logic                  rs_used;
    logic                  rt_used;
    logic                  stall;

    logic                  write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu;
    logic [REG_ADDR_W-1:0] write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu;
    logic                  write_float_misc, write_float_alu, write_float_mem, write_float_fpu;

    logic [TOTAL_W-1:0]    outstanding_total;
    logic                  underflow_error;

    // Decode / writeback side drives requests and observes status.
    modport master (
        output issue_valid, issue_addr, issue_float,
        output rs_addr, rt_addr, rs_float, rt_float, rs_used, rt_used,
        output write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu,
        output write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu,
        output write_float_misc, write_float_alu, write_float_mem, write_float_fpu,
        input  issue_ready, stall, outstanding_total, underflow_error
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_addr, issue_float,
        input  rs_addr, rt_addr, rs_float, rt_float, rs_used, rt_used,
        input  write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu,
        input  write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu,
        input  write_float_misc, write_float_alu, write_float_mem, write_float_fpu,
        output issue_ready, stall, outstanding_total, underflow_error
    );

endinterface

// File: rtl/register_scoreboard_entry.sv
// One outstanding-write counter: +inc -dec per cycle, clamped at zero.
module scoreboard_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic [2:0]       dec_i,
    output logic             busy_o,
    output logic             busy_bypass_o,
    output logic             saturated_o,
    output logic             underflow_o,
    output logic [CNT_W-1:0] count_d_o
);

    // Wide enough for count+1 and for a decrement of up to 4.
    localparam int EW = (((CNT_W + 1) > 3) ? (CNT_W + 1) : 3) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [EW-1:0]    cur_ext;
    logic [EW-1:0]    avail;
    logic [EW-1:0]    dec_ext;

    // Next count with underflow clamp; bypass busy ignores this cycle's issue.
    always_comb begin
        cur_ext     = EW'(count_q);
        avail       = cur_ext + EW'(inc_i);
        dec_ext     = EW'(dec_i);
        underflow_o = 1'b0;
        count_d     = '0;
        if (dec_ext > avail) begin
            underflow_o = 1'b1;
        end else begin
            count_d = CNT_W'(avail - dec_ext);
        end
    end

    assign busy_o        = (count_q != '0);
    assign busy_bypass_o = (cur_ext > dec_ext);
    assign saturated_o   = &count_q;
    assign count_d_o     = count_d;

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard: counts in-flight writes per register and stalls decode
// on pending sources. Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle
// writeback release the stall immediately.
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int TOTAL_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    register_scoreboard_if.slave  sb
);

    logic [SB_ENTRIES-1:0] inc_vec, busy_vec, bypass_vec, sat_vec, uf_vec, busy_sel;
    logic [CNT_W-1:0]      count_d [SB_ENTRIES];
    logic [2:0]            dec_vec [SB_ENTRIES];

    logic                  wb_en  [NUM_WB_PORTS];
    logic [SB_IDX_W-1:0]   wb_idx [NUM_WB_PORTS];

    logic [SB_IDX_W-1:0]   issue_idx, rs_idx, rt_idx;
    logic                  issue_zero, stall_c, ready_c, accept;
    logic [TOTAL_W-1:0]    total_d, total_q;
    logic                  underflow_q;

    assign wb_en[0]  = sb.write_enable_misc;
    assign wb_en[1]  = sb.write_enable_alu;
    assign wb_en[2]  = sb.write_enable_mem;
    assign wb_en[3]  = sb.write_enable_fpu;
    assign wb_idx[0] = sb_index(sb.write_float_misc, sb.write_addr_misc);
    assign wb_idx[1] = sb_index(sb.write_float_alu,  sb.write_addr_alu);
    assign wb_idx[2] = sb_index(sb.write_float_mem,  sb.write_addr_mem);
    assign wb_idx[3] = sb_index(sb.write_float_fpu,  sb.write_addr_fpu);

    assign issue_idx  = sb_index(sb.issue_float, sb.issue_addr);
    assign rs_idx     = sb_index(sb.rs_float, sb.rs_addr);
    assign rt_idx     = sb_index(sb.rt_float, sb.rt_addr);
    assign issue_zero = is_int_zero(sb.issue_float, sb.issue_addr);

`ifdef SCOREBOARD_BYPASS_EN
    assign busy_sel = bypass_vec;
`else
    assign busy_sel = busy_vec;
`endif

    assign stall_c = (sb.rs_used && busy_sel[rs_idx]) || (sb.rt_used && busy_sel[rt_idx]);
    assign ready_c = !stall_c && (issue_zero || !sat_vec[issue_idx]);
    assign accept  = sb.issue_valid && ready_c && !issue_zero;

    genvar gi;
    generate
        for (gi = 0; gi < SB_ENTRIES; gi++) begin : g_entry
            if (gi == 0) begin : g_tie
                // Integer r0: never incremented or decremented, so never busy.
                assign inc_vec[gi] = 1'b0;
                assign dec_vec[gi] = 3'd0;
            end else begin : g_cnt
                assign inc_vec[gi] = accept && (issue_idx == SB_IDX_W'(gi));
                // Count matching enabled writeback ports.
                always_comb begin
                    dec_vec[gi] = 3'd0;
                    for (int p = 0; p < NUM_WB_PORTS; p++) begin
                        if (wb_en[p] && (wb_idx[p] == SB_IDX_W'(gi))) begin
                            dec_vec[gi] = dec_vec[gi] + 3'd1;
                        end
                    end
                end
            end

            scoreboard_entry #(.CNT_W(CNT_W)) u_entry (
                .clk           (clk),
                .reset         (reset),
                .inc_i         (inc_vec[gi]),
                .dec_i         (dec_vec[gi]),
                .busy_o        (busy_vec[gi]),
                .busy_bypass_o (bypass_vec[gi]),
                .saturated_o   (sat_vec[gi]),
                .underflow_o   (uf_vec[gi]),
                .count_d_o     (count_d[gi])
            );
        end
    endgenerate

    // Sum of all next-state counters, wrapping at the output width.
    always_comb begin
        total_d = '0;
        for (int i = 0; i < SB_ENTRIES; i++) begin
            total_d = total_d + TOTAL_W'(count_d[i]);
        end
    end

    // Registered total and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            total_q     <= total_d;
            underflow_q <= underflow_q | (|uf_vec);
        end
    end

    assign sb.stall             = stall_c;
    assign sb.issue_ready       = ready_c;
    assign sb.outstanding_total = total_q;
    assign sb.underflow_error   = underflow_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with an expectation queue and
// a negedge monitor that pops and compares.
module tb_register_scoreboard;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_scoreboard_if #(.TOTAL_W(8)) sb_if ();

    register_scoreboard #(.CNT_W(2), .TOTAL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    typedef struct {
        string      name;
        logic       stall;
        logic       ready;
        logic [7:0] total;
        logic       uf;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic cmp(input string n, input string f, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s.%s actual=%0d required=%0d", n, f, act, req);
        end
    endtask

    // Monitor: every falling edge, check all expectations queued this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "stall", int'(sb_if.stall), int'(e.stall));
            cmp(e.name, "issue_ready", int'(sb_if.issue_ready), int'(e.ready));
            cmp(e.name, "outstanding_total", int'(sb_if.outstanding_total), int'(e.total));
            cmp(e.name, "underflow_error", int'(sb_if.underflow_error), int'(e.uf));
            $display("vec %-14s stall=%0b ready=%0b total=%0d uf=%0b", e.name,
                     sb_if.stall, sb_if.issue_ready, sb_if.outstanding_total,
                     sb_if.underflow_error);
        end
    end

    task automatic expect_now(input string n, input logic s, input logic r,
                              input logic [7:0] t, input logic u);
        exp_t e;
        e.name  = n;
        e.stall = s;
        e.ready = r;
        e.total = t;
        e.uf    = u;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.issue_valid = 0; sb_if.issue_addr = 0; sb_if.issue_float = 0;
        sb_if.rs_addr = 0; sb_if.rt_addr = 0; sb_if.rs_float = 0; sb_if.rt_float = 0;
        sb_if.rs_used = 0; sb_if.rt_used = 0;
        sb_if.write_enable_misc = 0; sb_if.write_enable_alu = 0;
        sb_if.write_enable_mem = 0;  sb_if.write_enable_fpu = 0;
        sb_if.write_addr_misc = 0; sb_if.write_addr_alu = 0;
        sb_if.write_addr_mem = 0;  sb_if.write_addr_fpu = 0;
        sb_if.write_float_misc = 0; sb_if.write_float_alu = 0;
        sb_if.write_float_mem = 0;  sb_if.write_float_fpu = 0;
    endtask

    task automatic issue(input logic f, input logic [4:0] a);
        sb_if.issue_valid = 1; sb_if.issue_float = f; sb_if.issue_addr = a;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;

        // Reset state, source r5 not pending.
        sb_if.rs_used = 1; sb_if.rs_addr = 5;
        expect_now("reset_state", 0, 1, 0, 0);
        tick();

        // Issue int r5.
        idle(); issue(0, 5);
        expect_now("issue_r5", 0, 1, 0, 0);
        tick();

        // r5 pending; alu writeback arrives this cycle.
        idle(); sb_if.rs_used = 1; sb_if.rs_addr = 5; sb_if.issue_addr = 5;
        sb_if.write_enable_alu = 1; sb_if.write_addr_alu = 5;
`ifdef SCOREBOARD_BYPASS_EN
        expect_now("r5_wb_cycle", 0, 1, 1, 0);
`else
        expect_now("r5_wb_cycle", 1, 0, 1, 0);
`endif
        tick();
        sb_if.write_enable_alu = 0;
        expect_now("r5_released", 0, 1, 0, 0);
        tick();

        // Fill float r3 to saturation.
        idle(); issue(1, 3);
        expect_now("f3_issue0", 0, 1, 0, 0);
        tick();
        expect_now("f3_issue1", 0, 1, 1, 0);
        tick();
        expect_now("f3_issue2", 0, 1, 2, 0);
        tick();
        sb_if.issue_valid = 0;
        expect_now("f3_saturated", 0, 0, 3, 0);
        tick();

        // Two writebacks to f3 in one cycle.
        sb_if.write_enable_mem = 1; sb_if.write_addr_mem = 3; sb_if.write_float_mem = 1;
        sb_if.write_enable_fpu = 1; sb_if.write_addr_fpu = 3; sb_if.write_float_fpu = 1;
        expect_now("f3_double_wb", 0, 0, 3, 0);
        tick();
        idle(); sb_if.issue_float = 1; sb_if.issue_addr = 3;
        sb_if.rt_used = 1; sb_if.rt_addr = 3; sb_if.rt_float = 1;
        expect_now("f3_still_busy", 1, 0, 1, 0);
        tick();
        sb_if.rt_used = 0;
        sb_if.write_enable_fpu = 1; sb_if.write_addr_fpu = 3; sb_if.write_float_fpu = 1;
        expect_now("f3_last_wb", 0, 1, 1, 0);
        tick();

        // Int r0 is never tracked.
        idle(); issue(0, 0); sb_if.rs_used = 1; sb_if.rs_addr = 0;
        for (int i = 0; i < 3; i++) begin
            expect_now($sformatf("int_r0_%0d", i), 0, 1, 0, 0);
            tick();
        end

        // Float r0 is tracked.
        idle(); issue(1, 0);
        expect_now("f0_issue", 0, 1, 0, 0);
        tick();
        idle(); sb_if.rs_used = 1; sb_if.rs_float = 1; sb_if.rs_addr = 0;
        sb_if.write_enable_misc = 1; sb_if.write_float_misc = 1; sb_if.write_addr_misc = 0;
`ifdef SCOREBOARD_BYPASS_EN
        expect_now("f0_busy", 0, 1, 1, 0);
`else
        expect_now("f0_busy", 1, 0, 1, 0);
`endif
        tick();

        // Int r7: count 1, then issue + writeback same cycle.
        idle(); issue(0, 7);
        expect_now("r7_issue", 0, 1, 0, 0);
        tick();
        sb_if.write_enable_misc = 1; sb_if.write_addr_misc = 7;
        expect_now("r7_issue_wb", 0, 1, 1, 0);
        tick();
        idle(); sb_if.rt_used = 1; sb_if.rt_addr = 7;
        sb_if.write_enable_alu = 0; sb_if.write_addr_alu = 7;   // disabled port
        expect_now("r7_net_zero", 1, 0, 1, 0);
        tick();
        expect_now("r7_disabled_wb", 1, 0, 1, 0);
        tick();

        // Writeback to int r0 must not underflow.
        idle(); sb_if.write_enable_misc = 1; sb_if.write_addr_misc = 0;
        expect_now("wb_int_r0", 0, 1, 1, 0);
        tick();
        // Underflow on int r9.
        idle(); sb_if.write_enable_misc = 1; sb_if.write_addr_misc = 9;
        expect_now("r9_wb_zero", 0, 1, 1, 0);
        tick();
        idle();
        expect_now("underflow_set", 0, 1, 1, 1);
        tick();
        expect_now("underflow_hold", 0, 1, 1, 1);
        tick();

        // Reset mid-operation with a writeback to r7 in the reset cycle.
        reset = 1;
        sb_if.write_enable_alu = 1; sb_if.write_addr_alu = 7;
        expect_now("pre_reset", 0, 1, 1, 1);
        tick();
        reset = 0;
        idle(); sb_if.rt_used = 1; sb_if.rt_addr = 7;
        expect_now("post_reset", 0, 1, 0, 0);
        tick();

        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
